// File: rtl/base_tdec_ramp_le.sv
`default_nettype none
// ============================================================================
//  Module   : base_tdec_ramp_le
//  Purpose  : Rate-limited thermometer decoder. An encoded target level is
//             accepted on a valid/ready handshake, clamped to dec_width, and
//             the registered little-endian thermometer output ramps toward
//             it by at most `step` levels per clock.
//  Options  : BASE_TDEC_RAMP_RETARGET_EN - when defined, targets are accepted
//             at any time (o_r tied high) and a new target mid-ramp takes
//             effect on the accept edge.
//  Revision : 1.0 - initial release
// ============================================================================
module base_tdec_ramp_le #(
  parameter int enc_width = 4,
  parameter int dec_width = 8,
  parameter int step      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_v,
  output logic                 o_r,
  input  logic [enc_width-1:0] i_d,
  output logic [dec_width-1:0] o_d,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int LW = $clog2(dec_width + 1);
  // Compare width wide enough for both the raw input and the level range
  localparam int CW = (enc_width > LW) ? enc_width : LW;
  localparam logic [CW-1:0] c_MAX_CMP = CW'(dec_width);
  localparam logic [LW-1:0] c_STEP    = LW'(step);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [LW-1:0]        r_lvl;
  logic [LW-1:0]        r_tgt;
  logic [LW-1:0]        w_lvl_nx;
  logic [LW-1:0]        w_t_eff;
  logic [LW-1:0]        w_clamp;
  logic [LW-1:0]        w_diff_up;
  logic [LW-1:0]        w_diff_dn;
  logic [LW-1:0]        w_amt_up;
  logic [LW-1:0]        w_amt_dn;
  logic [CW-1:0]        w_id_ext;
  logic                 w_acc;
  logic                 w_active;
  logic                 w_done_nx;
  logic [dec_width-1:0] w_therm;
  logic [dec_width-1:0] r_d;
  logic                 r_done;

  assign o_busy = (r_state != S_IDLE);

`ifdef BASE_TDEC_RAMP_RETARGET_EN
  assign o_r = 1'b1;
`else
  assign o_r = ~o_busy;
`endif

  assign w_acc    = i_v & o_r;
  assign w_active = o_busy | w_acc;

  // Clamp the encoded target to the top level rather than wrapping
  assign w_id_ext = CW'(i_d);
  assign w_clamp  = (w_id_ext > c_MAX_CMP) ? LW'(c_MAX_CMP) : LW'(w_id_ext);

  // The target in force on this edge: a fresh accept overrides the stored one
  assign w_t_eff   = w_acc ? w_clamp : r_tgt;
  assign w_diff_up = w_t_eff - r_lvl;
  assign w_diff_dn = r_lvl - w_t_eff;
  assign w_amt_up  = (w_diff_up < c_STEP) ? w_diff_up : c_STEP;
  assign w_amt_dn  = (w_diff_dn < c_STEP) ? w_diff_dn : c_STEP;

  // Next level, next state and completion; the level only moves while already
  // ramping, which gives the one-cycle latency after an accept from idle
  always_comb begin
    w_lvl_nx   = r_lvl;
    w_state_nx = r_state;
    w_done_nx  = 1'b0;
    if (o_busy) begin
      if (w_t_eff > r_lvl) begin
        w_lvl_nx = r_lvl + w_amt_up;
      end else if (w_t_eff < r_lvl) begin
        w_lvl_nx = r_lvl - w_amt_dn;
      end
    end
    if (w_active) begin
      if (w_lvl_nx == w_t_eff) begin
        w_state_nx = S_IDLE;
        w_done_nx  = 1'b1;
      end else if (w_t_eff > w_lvl_nx) begin
        w_state_nx = S_UP;
      end else begin
        w_state_nx = S_DOWN;
      end
    end
  end

  // Thermometer of the next level so o_d is a plain register of the level
  for (genvar gi = 0; gi < dec_width; gi++) begin : g_therm
    assign w_therm[gi] = (gi < int'(w_lvl_nx));
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Level, target, thermometer output and done pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lvl  <= '0;
      r_tgt  <= '0;
      r_d    <= '0;
      r_done <= 1'b0;
    end else begin
      r_lvl  <= w_lvl_nx;
      r_tgt  <= w_t_eff;
      r_d    <= w_therm;
      r_done <= w_done_nx;
    end
  end

  assign o_d    = r_d;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: doc/base_tdec_ramp_le.md
BASE_TDEC_RAMP_LE -- requirements
Module: base_tdec_ramp_le

Interface
REQ-001 SHALL have parameter enc_width, default 4, meaning width of encoded target input.
REQ-002 SHALL have parameter dec_width, default 8, meaning thermometer output width (max level).
REQ-003 SHALL have parameter step, default 1, meaning max level change per cycle (1..dec_width).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_v  input  1  target valid.
REQ-007 SHALL have port o_r  output  1  ready to accept target.
REQ-008 SHALL have port i_d  input  enc_width  encoded target level, unsigned.
REQ-009 SHALL have port o_d  output  dec_width  registered little-endian thermometer of current level.
REQ-010 SHALL have port o_busy  output  1  ramp in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse when level reaches target.

Function
REQ-012 SHALL hold internal level L, width $clog2(dec_width+1), and target T of the same width.
REQ-013 SHALL drive o_d[i] = 1 iff i < L, for every i; o_d is a flop output, not decoded from i_d combinationally.
REQ-014 SHALL accept a target on a clk edge where i_v & o_r; T <= min(i_d, dec_width) (clamp, no wrap).
REQ-015 SHALL implement states IDLE, UP, DOWN; on accept: T>L -> UP, T<L -> DOWN, T==L -> stay IDLE.
REQ-016 SHALL in UP add min(step, T-L) to L per edge; in DOWN subtract min(step, L-T); never overshoot, never underflow below 0 or exceed dec_width.
REQ-017 SHALL first change L on the edge after the accept edge (one-cycle latency).
REQ-018 SHALL return to IDLE on the edge where L becomes T, and assert o_done for exactly the following cycle.
REQ-019 SHALL, on accept with T==L, assert o_done for exactly the cycle after the accept edge.
REQ-020 SHALL drive o_busy = 1 iff state is UP or DOWN.
REQ-021 SHALL ignore i_d whenever i_v & o_r is false.

Reset
REQ-022 SHALL, on reset_n low, immediately and asynchronously set L=0, T=0, state IDLE, o_d=0, o_done=0, o_busy=0.
REQ-023 SHALL drive o_r=1 while reset_n is low and in the cycle after release.
REQ-024 SHALL abandon any ramp in progress on reset with no o_done pulse.

Configuration
REQ-025 SHALL support macro BASE_TDEC_RAMP_RETARGET_EN.
REQ-026 SHALL, with BASE_TDEC_RAMP_RETARGET_EN defined, hold o_r=1 always; an accept mid-ramp replaces T and re-selects UP/DOWN/IDLE from the current L on that edge, and the level step on that edge uses the new T.
REQ-027 SHALL, without BASE_TDEC_RAMP_RETARGET_EN, drive o_r = ~o_busy, so no target is accepted while ramping.

Verification (enc_width=4, dec_width=8, step=2 unless stated)
REQ-028 SHALL cover: reset pulse -> o_d=8'h00, o_r=1, o_busy=0, o_done=0.
REQ-029 SHALL cover: from L=0 accept i_d=5 at edge k -> o_d=8'h03 @k+1, 8'h0F @k+2, 8'h1F @k+3, o_done=1 only in cycle after k+3, o_busy high k+1..k+2.
REQ-030 SHALL cover: from L=0 accept i_d=12 -> clamped, o_d reaches 8'hFF after 4 edges, never wraps.
REQ-031 SHALL cover: from L=8 accept i_d=3 -> o_d 8'h3F, 8'h0F, 8'h07, then o_done; plus accept i_d=3 again -> no o_d change, o_done next cycle.
REQ-032 SHALL cover: reset_n low mid-ramp between edges -> o_d=8'h00 before next edge, no o_done.
REQ-033 SHALL cover: with BASE_TDEC_RAMP_RETARGET_EN, at L=4 ramping to 8 accept i_d=1 -> o_d 8'h03, 8'h01, o_done; without it, o_r=0 during ramp and the i_v is not taken.
